// File: rtl/dds_wavegen_if.sv
// dds_wavegen_if: control, ROM and DAC-side signals of the DDS waveform core.
// Build option DDS_QUARTER_WAVE_EN narrows rom_addr to a quarter-wave table.
interface dds_wavegen_if #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8
);
`ifdef DDS_QUARTER_WAVE_EN
    localparam int ROM_AW = ADDR_W - 2;
`else
    localparam int ROM_AW = ADDR_W;
`endif

    logic               en;
    logic               cfg_load;
    logic [PHASE_W-1:0] freq_word;
    logic [ADDR_W-1:0]  phase_off;
    logic [1:0]         mode;
    logic [DATA_W-1:0]  amp;
    logic               cfg_busy;
    logic [ROM_AW-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_q;
    logic [DATA_W-1:0]  dac_value;
    logic               dac_valid;
    logic               sync;

    modport master (
        output en, cfg_load, freq_word, phase_off, mode, amp, rom_q,
        input  cfg_busy, rom_addr, dac_value, dac_valid, sync
    );

    modport slave (
        input  en, cfg_load, freq_word, phase_off, mode, amp, rom_q,
        output cfg_busy, rom_addr, dac_value, dac_valid, sync
    );
endinterface

// File: rtl/dds_wavegen.sv
// dds_wavegen: phase-accumulator DDS producing sine/square/triangle/sawtooth,
// amplitude-scaled, with a shadow config committed at phase wrap.
// Build option DDS_QUARTER_WAVE_EN: external ROM holds one quarter of the sine.
module dds_wavegen #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    dds_wavegen_if.slave dds
);

`ifdef DDS_QUARTER_WAVE_EN
    localparam int ROM_AW = ADDR_W - 2;
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MID_M1 = {1'b0, {(DATA_W-1){1'b1}}};
`else
    localparam int ROM_AW = ADDR_W;
`endif

    // Active and shadow configuration
    logic [PHASE_W-1:0] freq_q, sh_freq_q;
    logic [1:0]         mode_q, sh_mode_q;
    logic [DATA_W-1:0]  amp_q,  sh_amp_q;
    logic [ADDR_W-1:0]  off_q,  sh_off_q;
    logic               busy_q;

    // Stage 0
    logic [PHASE_W-1:0] phase_q;
    logic               wrap_q;

    // Stage 1 (only the index bits the waveforms need are carried on)
    logic [ROM_AW-1:0]  rom_addr_q;
    logic [DATA_W:0]    idx1_q;
    logic [1:0]         mode1_q;
    logic [DATA_W-1:0]  amp1_q;
    logic               wrap1_q, en1_q;

    // Stage 2
    logic [DATA_W:0]    idx2_q;
    logic [1:0]         mode2_q;
    logic [DATA_W-1:0]  amp2_q;
    logic               wrap2_q, en2_q;

    // Stage 3
    logic [DATA_W-1:0]  dac_q;
    logic               valid_q, sync_q;

    logic [PHASE_W:0]   sum_d;
    logic               wrap_d, commit_d;
    logic [ADDR_W-1:0]  idx_d;
    logic [ROM_AW-1:0]  rom_addr_d;
    logic [DATA_W-1:0]  sine_d, raw_d, dac_d;
    logic [DATA_W:0]    amp_p1_d;
    logic [2*DATA_W:0]  prod_d;

    // Accumulator sum, wrap detection, commit decision and ROM addressing
    always_comb begin
        sum_d    = {1'b0, phase_q} + {1'b0, freq_q};
        wrap_d   = dds.en & sum_d[PHASE_W];
        commit_d = busy_q & (wrap_d | ~dds.en);
        idx_d    = phase_q[PHASE_W-1 -: ADDR_W] + off_q;
`ifdef DDS_QUARTER_WAVE_EN
        rom_addr_d = idx_d[ADDR_W-2] ? ~idx_d[ADDR_W-3:0] : idx_d[ADDR_W-3:0];
`else
        rom_addr_d = idx_d;
`endif
    end

    // Waveform selection and amplitude scaling of the sample in stage 2
    always_comb begin
`ifdef DDS_QUARTER_WAVE_EN
        sine_d = idx2_q[DATA_W] ? (MID_M1 - dds.rom_q) : (MID + dds.rom_q);
`else
        sine_d = dds.rom_q;
`endif
        case (mode2_q)
            2'd0:    raw_d = sine_d;
            2'd1:    raw_d = idx2_q[DATA_W] ? '0 : '1;
            2'd2:    raw_d = idx2_q[DATA_W] ? ~idx2_q[DATA_W-1:0] : idx2_q[DATA_W-1:0];
            default: raw_d = idx2_q[DATA_W:1];
        endcase
        amp_p1_d = {1'b0, amp2_q} + {{DATA_W{1'b0}}, 1'b1};
        prod_d   = {{(DATA_W+1){1'b0}}, raw_d} * {{DATA_W{1'b0}}, amp_p1_d};
        dac_d    = DATA_W'(prod_d >> DATA_W);
    end

    // Shadow capture and commit; a load on the commit cycle keeps the new shadow pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_freq_q <= '0;
            sh_mode_q <= '0;
            sh_amp_q  <= '0;
            sh_off_q  <= '0;
            busy_q    <= 1'b0;
            freq_q    <= '0;
            mode_q    <= '0;
            amp_q     <= '1;
            off_q     <= '0;
        end else begin
            if (dds.cfg_load) begin
                sh_freq_q <= dds.freq_word;
                sh_mode_q <= dds.mode;
                sh_amp_q  <= dds.amp;
                sh_off_q  <= dds.phase_off;
                busy_q    <= 1'b1;
            end else if (commit_d) begin
                busy_q    <= 1'b0;
            end
            if (commit_d) begin
                freq_q <= sh_freq_q;
                mode_q <= sh_mode_q;
                amp_q  <= sh_amp_q;
                off_q  <= sh_off_q;
            end
        end
    end

    // Stage 0: phase advance; wrap flag is held while en is low so sync
    // lands on the first valid sample of the new period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (dds.en) begin
            phase_q <= sum_d[PHASE_W-1:0];
            wrap_q  <= sum_d[PHASE_W];
        end
    end

    // Stage 1: ROM address and per-sample context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            idx1_q     <= '0;
            mode1_q    <= '0;
            amp1_q     <= '1;
            wrap1_q    <= 1'b0;
            en1_q      <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            idx1_q     <= idx_d[ADDR_W-1 -: DATA_W+1];
            mode1_q    <= mode_q;
            amp1_q     <= amp_q;
            wrap1_q    <= wrap_q & dds.en;
            en1_q      <= dds.en;
        end
    end

    // Stage 2: context aligned with the ROM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx2_q  <= '0;
            mode2_q <= '0;
            amp2_q  <= '1;
            wrap2_q <= 1'b0;
            en2_q   <= 1'b0;
        end else begin
            idx2_q  <= idx1_q;
            mode2_q <= mode1_q;
            amp2_q  <= amp1_q;
            wrap2_q <= wrap1_q;
            en2_q   <= en1_q;
        end
    end

    // Stage 3: registered DAC sample and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            dac_q   <= dac_d;
            valid_q <= en2_q;
            sync_q  <= wrap2_q;
        end
    end

    assign dds.cfg_busy  = busy_q;
    assign dds.rom_addr  = rom_addr_q;
    assign dds.dac_value = dac_q;
    assign dds.dac_valid = valid_q;
    assign dds.sync      = sync_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: random and directed stimulus against a sample-level model.
module tb_dds_wavegen;
    localparam int PW = 32;
    localparam int AW = 11;
    localparam int DW = 8;
`ifdef DDS_QUARTER_WAVE_EN
    localparam int RAW = AW - 2;
    localparam bit QW  = 1'b1;
`else
    localparam int RAW = AW;
    localparam bit QW  = 1'b0;
`endif
    localparam longint unsigned PMOD = 64'd1 << PW;
    localparam int unsigned AMOD = 1 << AW;
    localparam int unsigned QLEN = 1 << (AW - 2);
    localparam int unsigned MID  = 1 << (DW - 1);
    localparam int unsigned DMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_wavegen_if #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dif ();
    dds_wavegen #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .dds(dif)
    );

    // Sine table: random quarter magnitudes, full table built from the quadrant rule
    int unsigned   mag [QLEN];
    logic [DW-1:0] rom_mem [1 << RAW];
    always @(posedge clk) dif.rom_q <= rom_mem[dif.rom_addr];

    typedef struct {
        bit          valid;
        bit          sync;
        int unsigned value;
    } samp_t;

    longint unsigned m_phase, m_freq, s_freq;
    int unsigned     m_mode, m_amp, m_off, s_mode, s_amp, s_off, m_addr;
    bit              m_busy, m_wrap;
    samp_t           pipe[$];
    int              n_checks = 0;
    int              n_errors = 0;

    function automatic int unsigned sine_ref(int unsigned idx);
        int unsigned q, a, m;
        q = idx / QLEN;
        a = idx % QLEN;
        m = (q % 2 == 1) ? mag[QLEN - 1 - a] : mag[a];
        return (q >= 2) ? (MID - 1 - m) : (MID + m);
    endfunction

    function automatic int unsigned wave_ref(int unsigned md, int unsigned idx, int unsigned a);
        int unsigned raw, half, step;
        half = AMOD / 2;
        step = half >> DW;
        case (md)
            0:       raw = sine_ref(idx);
            1:       raw = (idx < half) ? DMAX : 0;
            2:       raw = (idx < half) ? idx / step : DMAX - (idx - half) / step;
            default: raw = idx / (AMOD >> DW);
        endcase
        return (raw * (a + 1)) >> DW;
    endfunction

    function automatic int unsigned addr_ref(int unsigned idx);
        int unsigned q, a;
        q = idx / QLEN;
        a = idx % QLEN;
        if (QW) return (q % 2 == 1) ? (QLEN - 1 - a) : a;
        return idx;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_freq = 0; s_freq = 0;
        m_mode = 0; m_amp = DMAX; m_off = 0;
        s_mode = 0; s_amp = 0; s_off = 0;
        m_busy = 1'b0; m_wrap = 1'b0; m_addr = 0;
        pipe.delete();
    endtask

    // One clock of the behavioural model, using the inputs present at the edge
    task automatic model_edge();
        int unsigned idx;
        bit          en_v, carry, commit;
        samp_t       s;
        en_v    = dif.en;
        idx     = int'(((m_phase >> (PW - AW)) + m_off) % AMOD);
        s.valid = en_v;
        s.sync  = en_v && m_wrap;
        s.value = wave_ref(m_mode, idx, m_amp);
        pipe.push_back(s);
        if (pipe.size() > 3) void'(pipe.pop_front());
        m_addr = addr_ref(idx);
        carry  = en_v && (m_phase + m_freq >= PMOD);
        commit = m_busy && (carry || !en_v);
        if (en_v) begin
            m_phase = (m_phase + m_freq) % PMOD;
            m_wrap  = carry;
        end
        if (commit) begin
            m_freq = s_freq; m_mode = s_mode; m_amp = s_amp; m_off = s_off;
        end
        if (dif.cfg_load) begin
            s_freq = dif.freq_word; s_mode = dif.mode; s_amp = dif.amp; s_off = dif.phase_off;
            m_busy = 1'b1;
        end else if (commit) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic compare();
        samp_t e;
        if (pipe.size() == 3) e = pipe[0];
        else e = '{1'b0, 1'b0, 0};
        check("dac_valid", 64'(dif.dac_valid), 64'(e.valid));
        check("sync", 64'(dif.sync), 64'(e.sync));
        if (e.valid) check("dac_value", 64'(dif.dac_value), 64'(e.value));
        check("cfg_busy", 64'(dif.cfg_busy), 64'(m_busy));
        check("rom_addr", 64'(dif.rom_addr), 64'(m_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input logic [PW-1:0] f, input int unsigned md,
                        input int unsigned a, input int unsigned off);
        dif.freq_word = f;
        dif.mode      = 2'(md);
        dif.amp       = DW'(a);
        dif.phase_off = AW'(off);
        dif.cfg_load  = 1'b1;
        tick();
        dif.cfg_load  = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_dac_value"}, 64'(dif.dac_value), 64'd0);
        check({pfx, "_dac_valid"}, 64'(dif.dac_valid), 64'd0);
        check({pfx, "_sync"}, 64'(dif.sync), 64'd0);
        check({pfx, "_cfg_busy"}, 64'(dif.cfg_busy), 64'd0);
        check({pfx, "_rom_addr"}, 64'(dif.rom_addr), 64'd0);
    endtask

    initial begin
        dif.en = 1'b0; dif.cfg_load = 1'b0; dif.freq_word = '0;
        dif.phase_off = '0; dif.mode = '0; dif.amp = '0;
        for (int i = 0; i < int'(QLEN); i++) mag[i] = $urandom_range(0, MID - 1);
        for (int i = 0; i < (1 << RAW); i++)
            rom_mem[i] = DW'(QW ? mag[i] : sine_ref(i));
        model_reset();

        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Sawtooth, full amplitude; idle load commits on the next clock
        load(32'h0020_0000, 3, 255, 0);
        tick();
        dif.en = 1'b1;
        run(2 * 2048 + 16);

        // Square at reduced amplitude, then triangle: both commit at a wrap
        load(32'h0020_0000, 1, 127, 0);
        run(4200);
        load(32'h0020_0000, 2, 255, 0);
        run(4200);

        // Square running, two loads mid-period (last wins), sawtooth at half period
        load(32'h0020_0000, 1, 255, 0);
        run(3000);
        load(32'h0020_0000, 3, 200, 0);
        run(200);
        load(32'h0040_0000, 3, 255, 0);
        run(3000);

        // Sine through the ROM with a phase offset
        load(32'h0020_0000, 0, 255, 512);
        run(4200);

        // Frozen phase: pending config waits until en drops
        load(32'h0000_0000, 2, 255, 0);
        run(2100);
        load(32'h0020_0000, 3, 255, 7);
        run(40);
        dif.en = 1'b0;
        run(2);
        dif.en = 1'b1;
        run(200);

        // Randomised configs, enables and idle-bus noise
        for (int i = 0; i < 4000; i++) begin
            dif.en        = ($urandom_range(0, 7) != 0);
            dif.freq_word = PW'($urandom >> $urandom_range(0, 12));
            dif.mode      = 2'($urandom);
            dif.amp       = DW'($urandom);
            dif.phase_off = AW'($urandom);
            dif.cfg_load  = ($urandom_range(0, 49) == 0);
            tick();
        end
        dif.cfg_load = 1'b0;
        dif.en = 1'b1;
        run(50);

        // Asynchronous reset in mid-period
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dif.en = 1'b1;
        tick();
        check("arst_valid_c1", 64'(dif.dac_valid), 64'd0);
        tick();
        check("arst_valid_c2", 64'(dif.dac_valid), 64'd0);
        tick();
        check("arst_valid_c3", 64'(dif.dac_valid), 64'd1);
        run(10);
        load(32'h0100_0000, 2, 99, 300);
        run(600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dds_wavegen.md
# dds_wavegen

Parametrised direct-digital-synthesis waveform core, the next generation of our signal generator's DAC path. A phase accumulator drives an external sine ROM (synchronous, one-cycle read latency, same style as our existing sine table) and generates sine, square, triangle or sawtooth. Each sample is scaled by an amplitude word and presented as an unsigned DAC code for the DAC driver. New configurations are loaded through a shadow register and committed at a phase wrap, so frequency, mode and amplitude changes are glitch-free.

## Interface
- PHASE_W, 32: phase accumulator width.
- ADDR_W, 11: phase index width (top bits of accumulator); constraint ADDR_W >= DATA_W+1, PHASE_W > ADDR_W.
- DATA_W, 8: sample / DAC code width.

- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator advance enable.
- cfg_load  in  1  one-cycle strobe capturing freq_word/mode/amp/phase_off into shadow.
- freq_word  in  PHASE_W  phase increment per clk.
- phase_off  in  ADDR_W  phase offset added to index.
- mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- amp  in  DATA_W  amplitude; full scale = all ones.
- cfg_busy  out  1  shadow holds an uncommitted config.
- rom_addr  out  ADDR_W (ADDR_W-2 with quarter-wave)  sine ROM address, registered.
- rom_q  in  DATA_W  ROM data, valid one clk after rom_addr.
- dac_value  out  DATA_W  registered output sample.
- dac_valid  out  1  dac_value is a fresh sample (en was high 3 cycles earlier).
- sync  out  1  one-cycle pulse with the first sample after a phase wrap.

## Operation
- Reset values: phase_acc 0, active freq 0, mode 0, amp all-ones, phase_off 0, cfg_busy 0, rom_addr 0, dac_value 0, dac_valid 0, sync 0; shadow cleared.
- Stage 0: if en, phase_acc <= phase_acc + freq_word (modulo 2^PHASE_W); wrap = carry out. en=0 holds phase_acc, no wrap.
- Stage 1: idx = phase_acc[PHASE_W-1 -: ADDR_W] + phase_off (modulo 2^ADDR_W); register rom_addr, idx, mode, amp, wrap, en.
- Stage 2: ROM data returns; non-ROM modes computed from the delayed idx: square = idx MSB ? 0 : all-ones; sawtooth = idx[ADDR_W-1 -: DATA_W]; triangle = t or ~t with t = idx[ADDR_W-2 -: DATA_W], inverted when idx MSB = 1; sine = rom_q.
- Stage 3: dac_value <= (raw * (amp+1)) >> DATA_W (DATA_W+DATA_W+1-bit product, truncation); dac_valid and sync are delayed copies of en and wrap.
- Config handshake: cfg_load copies inputs to shadow and sets cfg_busy. Commit to active regs occurs on the cycle a wrap is generated, or immediately on the next clk if en=0. Commit clears cfg_busy. cfg_load while busy overwrites shadow (last write wins); cfg_load on the commit cycle wins: the new shadow is kept and cfg_busy stays 1.
- freq_word=0 with en=1: phase frozen, no wrap; a pending config then commits only after en drops.
- Mid-operation rst clears the pipeline immediately; the first valid sample appears 3 clks after rst release with en=1.

## Timing
- Latency: phase_acc update to dac_value = 3 clk; rom_addr to rom_q = 1 clk.
- Output period = 2^PHASE_W / freq_word clks; sync spacing equals the period in clks.
- Mode/amp/freq changes take effect on the sample whose phase follows the wrap; no partial periods mix old and new mode.
- All outputs registered; no combinational input-to-output path.

## Configuration
- DDS_QUARTER_WAVE_EN defined: ROM holds one quarter (2^(ADDR_W-2) entries, unsigned magnitude 0..2^(DATA_W-1)-1). Quadrant q = idx[ADDR_W-1:ADDR_W-2]. rom_addr = q[0] ? ~idx[ADDR_W-3:0] : idx[ADDR_W-3:0]. Sine = q[1] ? mid-1-mag : mid+mag, with mid = 2^(DATA_W-1). The quadrant bits are pipelined with the ROM read.
- Undefined: full-period ROM of 2^ADDR_W entries, and the sine output is rom_q directly.

## Test plan
- Defaults, reset, freq_word=2^21, mode 3, amp 255, en=1 -> dac_value steps 0,1,…,255 with 8 clks per step; sync every 2048 clks; first valid 3 clks after en.
- Mode 1, freq_word=2^21, amp 255 -> 1024 clks at 255, then 1024 clks at 0; amp 127 -> high level (255*128)>>8 = 127.
- Mode 2, freq_word=2^21 -> rises 0→255 over 1024 clks, falls 255→0 over the next 1024; no step >1.
- Running square, cfg_load mode 3 at mid-period, then a second cfg_load with freq 2^22 -> cfg_busy high until the next wrap; the next sample after sync is a sawtooth at 1024-clk period.
- Mode 0 with a ROM model, phase_off=512 -> rom_addr sequence starts at 512; quarter-wave build matches the full-table output code for code.
- Assert rst mid-period -> all outputs 0 within the same cycle (asynchronous); after release with en=1, dac_valid rises 3 clks later at phase 0.
